// File: rtl/mem_access.sv
// mem_access: memory-access stage of the 16-bit pipeline.
//
// ALU results pass straight through to the write-back triple. Loads and
// stores to the external SRAM or the memory-mapped UART data register run
// through a three-state sequence (IDLE detect, ACC1 strobe, ACC2 hold). A
// load from the UART status register is answered in the same cycle.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   wData_i/wReg_i/wRegAddr_i   write-back triple from EX/MEM
//   memOp_i             00 none, 01 load, 10 store, 11 none
//   memAddr_i/memData_i effective address / store data
//   wData_o/wReg_o/wRegAddr_o   write-back triple to mem_wb
//   stallReq_o          stall request while an access is in flight
//   ramAddr_o           SRAM address (zero-extended memAddr_i)
//   ramData_io          shared SRAM/UART data bus
//   ramEN_n/ramOE_n/ramWE_n     active-low SRAM controls
//   uartRdn_o/uartWrn_o active-low UART strobes
//   dataReady_i/tbre_i/tsre_i   UART status inputs
module mem_access #(
  parameter int              DATA_W         = 16,
  parameter int              RAM_ADDR_W     = 18,
  parameter logic [DATA_W-1:0] UART_DATA_ADDR = 16'hBF00,
  parameter logic [DATA_W-1:0] UART_STAT_ADDR = 16'hBF01
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     wData_i,
  input  logic                  wReg_i,
  input  logic [3:0]            wRegAddr_i,
  input  logic [1:0]            memOp_i,
  input  logic [DATA_W-1:0]     memAddr_i,
  input  logic [DATA_W-1:0]     memData_i,
  output logic [DATA_W-1:0]     wData_o,
  output logic                  wReg_o,
  output logic [3:0]            wRegAddr_o,
  output logic                  stallReq_o,
  output logic [RAM_ADDR_W-1:0] ramAddr_o,
  inout  wire  [DATA_W-1:0]     ramData_io,
  output logic                  ramEN_n,
  output logic                  ramOE_n,
  output logic                  ramWE_n,
  output logic                  uartRdn_o,
  output logic                  uartWrn_o,
  input  logic                  dataReady_i,
  input  logic                  tbre_i,
  input  logic                  tsre_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC1 = 2'd1,
    ACC2 = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] rdq;
  logic              bus_oe;

  logic is_load, is_store, is_uart, is_stat_rd;
  logic [DATA_W-1:0] status_word;

  assign is_load    = (memOp_i == 2'b01);
  assign is_store   = (memOp_i == 2'b10);
  assign is_uart    = (memAddr_i == UART_DATA_ADDR);
  assign is_stat_rd = is_load && (memAddr_i == UART_STAT_ADDR);

  assign status_word = {{(DATA_W-2){1'b0}}, dataReady_i, tbre_i & tsre_i};

  assign ramAddr_o = {{(RAM_ADDR_W-DATA_W){1'b0}}, memAddr_i};

  // bus_oe is already forced low by reset in the output process
  assign ramData_io = bus_oe ? memData_i : {DATA_W{1'bz}};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      rdq   <= '0;
    end else begin
      state <= state_nxt;
      if (state == ACC1 && is_load)
        rdq <= ramData_io;
    end
  end

  always_comb begin
    state_nxt  = state;
    wData_o    = wData_i;
    wReg_o     = wReg_i;
    wRegAddr_o = wRegAddr_i;
    stallReq_o = 1'b0;
    ramEN_n    = 1'b1;
    ramOE_n    = 1'b1;
    ramWE_n    = 1'b1;
    uartRdn_o  = 1'b1;
    uartWrn_o  = 1'b1;
    bus_oe     = 1'b0;

    case (state)
      IDLE: begin
        if (is_stat_rd) begin
          wData_o = status_word;
        end else if (is_load || is_store) begin
          stallReq_o = 1'b1;
          state_nxt  = ACC1;
        end
      end
      ACC1: begin
        stallReq_o = 1'b1;
        state_nxt  = ACC2;
        bus_oe     = is_store;
        if (is_uart) begin
          uartRdn_o = ~is_load;
          uartWrn_o = ~is_store;
        end else begin
          ramEN_n = 1'b0;
          ramOE_n = ~is_load;
          ramWE_n = ~is_store;
        end
      end
      ACC2: begin
        // strobes already high; keeping the bus driven gives data hold
        state_nxt = IDLE;
        bus_oe    = is_store;
        if (is_load)
          wData_o = rdq;
      end
      default: state_nxt = IDLE;
    endcase

    // reset forces every output to its idle value without waiting for clk
    if (!rst) begin
      wData_o    = '0;
      wReg_o     = 1'b0;
      wRegAddr_o = '0;
      stallReq_o = 1'b0;
      ramEN_n    = 1'b1;
      ramOE_n    = 1'b1;
      ramWE_n    = 1'b1;
      uartRdn_o  = 1'b1;
      uartWrn_o  = 1'b1;
      bus_oe     = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] wData_i;
  logic        wReg_i;
  logic [3:0]  wRegAddr_i;
  logic [1:0]  memOp_i;
  logic [15:0] memAddr_i;
  logic [15:0] memData_i;
  logic [15:0] wData_o;
  logic        wReg_o;
  logic [3:0]  wRegAddr_o;
  logic        stallReq_o;
  logic [17:0] ramAddr_o;
  wire  [15:0] ramData_io;
  logic        ramEN_n, ramOE_n, ramWE_n, uartRdn_o, uartWrn_o;
  logic        dataReady_i, tbre_i, tsre_i;

  int n_cmp = 0;
  int n_err = 0;

  // SRAM and UART models
  logic [15:0] mem [256];
  logic [15:0] uart_rx;
  logic [15:0] uart_tx;
  logic        sram_drv, uart_drv;

  assign sram_drv   = !ramEN_n && !ramOE_n;
  assign uart_drv   = !uartRdn_o;
  assign ramData_io = sram_drv ? mem[ramAddr_o[7:0]] :
                      (uart_drv ? uart_rx : 16'hzzzz);

  always @(posedge clk) begin
    if (!ramEN_n && !ramWE_n) mem[ramAddr_o[7:0]] <= ramData_io;
    if (!uartWrn_o) uart_tx <= ramData_io;
  end

  mem_access dut (
    .clk(clk), .rst(rst),
    .wData_i(wData_i), .wReg_i(wReg_i), .wRegAddr_i(wRegAddr_i),
    .memOp_i(memOp_i), .memAddr_i(memAddr_i), .memData_i(memData_i),
    .wData_o(wData_o), .wReg_o(wReg_o), .wRegAddr_o(wRegAddr_o),
    .stallReq_o(stallReq_o), .ramAddr_o(ramAddr_o), .ramData_io(ramData_io),
    .ramEN_n(ramEN_n), .ramOE_n(ramOE_n), .ramWE_n(ramWE_n),
    .uartRdn_o(uartRdn_o), .uartWrn_o(uartWrn_o),
    .dataReady_i(dataReady_i), .tbre_i(tbre_i), .tsre_i(tsre_i)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Strobe vector {ramEN_n, ramOE_n, ramWE_n, uartRdn_o, uartWrn_o}
  function automatic logic [4:0] strobes();
    return {ramEN_n, ramOE_n, ramWE_n, uartRdn_o, uartWrn_o};
  endfunction

  // Full 3-cycle access; called just after a rising edge with DUT in IDLE.
  task automatic access(input logic [1:0] op, input logic [15:0] addr,
                        input logic [15:0] sdata, input logic [15:0] exp_w,
                        input string nm);
    logic uart, ld, st;
    uart = (addr == 16'hBF00);
    ld   = (op == 2'b01);
    st   = (op == 2'b10);
    memOp_i = op; memAddr_i = addr; memData_i = sdata;
    wData_i = 16'h7777; wReg_i = 1'b1; wRegAddr_i = 4'd5;
    @(negedge clk);
    chk({nm, " idle stall"}, stallReq_o, 1);
    chk({nm, " idle strobes"}, strobes(), 5'b11111);
    chk({nm, " ramAddr"}, ramAddr_o, {2'b00, addr});
    @(posedge clk); @(negedge clk);
    chk({nm, " acc1 stall"}, stallReq_o, 1);
    if (uart) chk({nm, " acc1 strobes"}, strobes(), {3'b111, ~ld, ~st});
    else      chk({nm, " acc1 strobes"}, strobes(), {1'b0, ~ld, ~st, 2'b11});
    if (st) chk({nm, " acc1 bus"}, ramData_io, sdata);
    @(posedge clk); @(negedge clk);
    chk({nm, " acc2 stall"}, stallReq_o, 0);
    chk({nm, " acc2 strobes"}, strobes(), 5'b11111);
    chk({nm, " acc2 wData"}, wData_o, exp_w);
    chk({nm, " acc2 wReg/addr"}, {wReg_o, wRegAddr_o}, {1'b1, 4'd5});
    if (st) chk({nm, " acc2 bus"}, ramData_io, sdata);
    @(posedge clk); #1;
    memOp_i = 2'b00;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [15:0] addr;
    logic [15:0] wd;
    logic        wr;
    logic [3:0]  wa;
    logic        dr, tb, ts;
    logic [15:0] exp_wd;
    logic        exp_wr;
    logic [3:0]  exp_wa;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{2'b00, 16'h0000, 16'h1234, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 16'h1234, 1'b1, 4'd3};
    vecs[1] = '{2'b11, 16'h0040, 16'hABCD, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 16'hABCD, 1'b0, 4'hF};
    vecs[2] = '{2'b01, 16'hBF01, 16'h9999, 1'b1, 4'd2, 1'b1, 1'b1, 1'b1, 16'h0003, 1'b1, 4'd2};
    vecs[3] = '{2'b01, 16'hBF01, 16'h9999, 1'b1, 4'd2, 1'b1, 1'b1, 1'b0, 16'h0002, 1'b1, 4'd2};
    vecs[4] = '{2'b01, 16'hBF01, 16'h9999, 1'b0, 4'd7, 1'b0, 1'b1, 1'b1, 16'h0001, 1'b0, 4'd7};
    vecs[5] = '{2'b00, 16'hBF01, 16'h5555, 1'b1, 4'd9, 1'b1, 1'b1, 1'b1, 16'h5555, 1'b1, 4'd9};

    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h40] = 16'hBEEF;
    uart_rx = 16'h00A5;
    uart_tx = 16'h0000;

    rst = 1'b0;
    memOp_i = 2'b00; memAddr_i = 16'h0000; memData_i = 16'h0000;
    wData_i = 16'h1234; wReg_i = 1'b1; wRegAddr_i = 4'd3;
    dataReady_i = 1'b0; tbre_i = 1'b0; tsre_i = 1'b0;

    // reset values
    #2;
    chk("reset wtriple", {wData_o, wReg_o, wRegAddr_o}, {16'h0000, 1'b0, 4'd0});
    chk("reset stall", stallReq_o, 0);
    chk("reset strobes", strobes(), 5'b11111);
    @(posedge clk); #1;
    rst = 1'b1;

    // single-cycle pass-through and status reads
    for (int i = 0; i < 6; i++) begin
      memOp_i = vecs[i].op; memAddr_i = vecs[i].addr; wData_i = vecs[i].wd;
      wReg_i = vecs[i].wr; wRegAddr_i = vecs[i].wa;
      dataReady_i = vecs[i].dr; tbre_i = vecs[i].tb; tsre_i = vecs[i].ts;
      @(negedge clk);
      chk($sformatf("vec%0d wtriple", i), {wData_o, wReg_o, wRegAddr_o},
          {vecs[i].exp_wd, vecs[i].exp_wr, vecs[i].exp_wa});
      chk($sformatf("vec%0d stall", i), stallReq_o, 0);
      chk($sformatf("vec%0d strobes", i), strobes(), 5'b11111);
      @(posedge clk); #1;
    end

    // SRAM load, store, load-back
    access(2'b01, 16'h0040, 16'h0000, 16'hBEEF, "sram load");
    access(2'b10, 16'h0041, 16'h5A5A, 16'h7777, "sram store");
    chk("sram mem[41]", mem[8'h41], 16'h5A5A);
    access(2'b01, 16'h0041, 16'h0000, 16'h5A5A, "sram reload");

    // UART write and read
    access(2'b10, 16'hBF00, 16'h0041, 16'h7777, "uart write");
    chk("uart tx", uart_tx, 16'h0041);
    access(2'b01, 16'hBF00, 16'h0000, 16'h00A5, "uart read");

    // reset in the middle of an ACC1 store to 0x0010
    memOp_i = 2'b10; memAddr_i = 16'h0010; memData_i = 16'hDEAD;
    @(posedge clk); #2;
    chk("rst pre WE", ramWE_n, 0);
    rst = 1'b0;
    #1;
    chk("rst async WE", ramWE_n, 1);
    chk("rst async stall", stallReq_o, 0);
    chk("rst async EN", ramEN_n, 1);
    chk("rst async wData", wData_o, 16'h0000);
    @(posedge clk); #1;
    chk("rst no write", mem[8'h10], 16'h0000);
    rst = 1'b1;
    access(2'b10, 16'h0010, 16'h1111, 16'h7777, "post-rst store");
    chk("post-rst mem[10]", mem[8'h10], 16'h1111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
